// File: rtl/demux_1x6_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : demux_1x6_reg_pkg
//  Description : Shared constants for the registered 1-to-6 demultiplexer.
//                Holds the destination count and the two illegal selector
//                codes. The data width stays a module parameter.
//  Revision    : 1.0 - initial release
// ============================================================================
package demux_1x6_reg_pkg;

  localparam int unsigned c_NUM_DEST      = 6;
  localparam logic [2:0]  c_SEL_ILLEGAL_6 = 3'd6;
  localparam logic [2:0]  c_SEL_ILLEGAL_7 = 3'd7;

  // True when the selector addresses one of the six destinations.
  function automatic logic sel_is_legal(input logic [2:0] sel);
    return (sel != c_SEL_ILLEGAL_6) && (sel != c_SEL_ILLEGAL_7);
  endfunction

endpackage
`default_nettype wire

// File: rtl/demux_1x6_reg_reg_en_clr.sv
`default_nettype none
// ============================================================================
//  Module      : reg_en_clr
//  Description : WIDTH-bit register with load enable, synchronous clear and
//                asynchronous active-low reset. Clear has priority over
//                enable.
//  Ports       : clk    - clock, rising edge
//                rst_n  - asynchronous active-low reset
//                i_en   - load enable
//                i_clr  - synchronous clear
//                i_d    - data to load
//                o_q    - registered value
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_en_clr #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/demux_1x6_reg.sv
`default_nettype none
// ============================================================================
//  Module      : demux_1x6_reg
//  Description : Registered 1-to-6 demultiplexer. A write loads Data_in into
//                the destination picked by Selector, pulses the matching
//                Load_strobe bit for one cycle and sets the sticky
//                Written_mask bit. Illegal selectors (6, 7) pulse Sel_error
//                and change nothing else. Clear wipes data and mask and wins
//                over Write. All outputs are registered.
//  Ports       : clk          - clock, rising edge
//                reset        - asynchronous active-low reset
//                Data_in      - write data (WIDTH bits)
//                Selector     - destination index, 0..5 legal
//                Write        - write request
//                Clear        - synchronous clear of data and mask
//                Data_0..5    - registered destination values
//                Load_strobe  - one-cycle pulse per loaded destination
//                Written_mask - sticky per-destination written flags
//                Sel_error    - one-cycle pulse after an illegal write
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_1x6_reg
  import demux_1x6_reg_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] Data_in,
  input  logic [2:0]       Selector,
  input  logic             Write,
  input  logic             Clear,
  output logic [WIDTH-1:0] Data_0,
  output logic [WIDTH-1:0] Data_1,
  output logic [WIDTH-1:0] Data_2,
  output logic [WIDTH-1:0] Data_3,
  output logic [WIDTH-1:0] Data_4,
  output logic [WIDTH-1:0] Data_5,
  output logic [5:0]       Load_strobe,
  output logic [5:0]       Written_mask,
  output logic             Sel_error
);

  // r_armed stays low for the first edge after reset release so that a
  // command sampled on that edge is dropped; commands are accepted from the
  // following edge onward.
  logic                   r_armed;
  logic [c_NUM_DEST-1:0]  r_strobe;
  logic [c_NUM_DEST-1:0]  r_mask;
  logic                   r_sel_err;

  logic                   w_accept;
  logic                   w_clr;
  logic                   w_err;
  logic [c_NUM_DEST-1:0]  w_en;
  logic [WIDTH-1:0]       w_data [c_NUM_DEST];

  assign w_accept = r_armed & Write & ~Clear;
  assign w_clr    = r_armed & Clear;
  assign w_err    = w_accept & ~sel_is_legal(Selector);

  // One-hot decode; codes 6 and 7 match no destination.
  always_comb begin
    w_en = '0;
    for (int k = 0; k < c_NUM_DEST; k++) begin
      w_en[k] = w_accept & (Selector == 3'(k));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_armed   <= 1'b0;
      r_strobe  <= '0;
      r_mask    <= '0;
      r_sel_err <= 1'b0;
    end else begin
      r_armed   <= 1'b1;
      r_strobe  <= w_en;
      r_sel_err <= w_err;
      if (w_clr) begin
        r_mask <= '0;
      end else begin
        r_mask <= r_mask | w_en;
      end
    end
  end

  generate
    for (genvar k = 0; k < c_NUM_DEST; k++) begin : g_dest
      reg_en_clr #(
        .WIDTH (WIDTH)
      ) u_reg (
        .clk   (clk),
        .rst_n (reset),
        .i_en  (w_en[k]),
        .i_clr (w_clr),
        .i_d   (Data_in),
        .o_q   (w_data[k])
      );
    end
  endgenerate

  assign Data_0       = w_data[0];
  assign Data_1       = w_data[1];
  assign Data_2       = w_data[2];
  assign Data_3       = w_data[3];
  assign Data_4       = w_data[4];
  assign Data_5       = w_data[5];
  assign Load_strobe  = r_strobe;
  assign Written_mask = r_mask;
  assign Sel_error    = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_demux_1x6_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_1x6_reg
//  Description : Testbench for demux_1x6_reg. Directed commands push their
//                expected output snapshot into a queue; a monitor pops one
//                snapshot after every rising edge and compares it with the
//                DUT outputs. Scenario-specific constant checks complement it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_1x6_reg;

  localparam int WIDTH = 32;

  typedef struct packed {
    logic [5:0][WIDTH-1:0] d;
    logic [5:0]            strobe;
    logic [5:0]            mask;
    logic                  err;
  } snap_t;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] Data_in;
  logic [2:0]       Selector;
  logic             Write;
  logic             Clear;
  logic [WIDTH-1:0] Data_0, Data_1, Data_2, Data_3, Data_4, Data_5;
  logic [5:0]       Load_strobe;
  logic [5:0]       Written_mask;
  logic             Sel_error;

  int    n_checks = 0;
  int    n_errors = 0;
  snap_t q_exp[$];
  snap_t m;
  logic  m_armed;

  demux_1x6_reg #(.WIDTH(WIDTH)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .Data_in      (Data_in),
    .Selector     (Selector),
    .Write        (Write),
    .Clear        (Clear),
    .Data_0       (Data_0),
    .Data_1       (Data_1),
    .Data_2       (Data_2),
    .Data_3       (Data_3),
    .Data_4       (Data_4),
    .Data_5       (Data_5),
    .Load_strobe  (Load_strobe),
    .Written_mask (Written_mask),
    .Sel_error    (Sel_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic snap_t actual();
    snap_t a;
    a.d      = {Data_5, Data_4, Data_3, Data_2, Data_1, Data_0};
    a.strobe = Load_strobe;
    a.mask   = Written_mask;
    a.err    = Sel_error;
    return a;
  endfunction

  // Monitor: one expected snapshot per edge after a command was issued.
  initial begin
    snap_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (q_exp.size() > 0) begin
        e = q_exp.pop_front();
        a = actual();
        n_checks++;
        if (a !== e) begin
          n_errors++;
          $display("FAIL snapshot t=%0t: got d5..d0=%h strobe=%b mask=%b err=%b, want d5..d0=%h strobe=%b mask=%b err=%b",
                   $time, a.d, a.strobe, a.mask, a.err, e.d, e.strobe, e.mask, e.err);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Drive one command for the next rising edge and record what that edge
  // must produce.
  task automatic step(input logic rst_v, input logic w, input logic c,
                      input logic [2:0] s, input logic [WIDTH-1:0] din);
    @(negedge clk);
    reset    = rst_v;
    Write    = w;
    Clear    = c;
    Selector = s;
    Data_in  = din;
    if (!rst_v) begin
      m       = '0;
      m_armed = 1'b0;
    end else if (!m_armed) begin
      m.strobe = '0;
      m.err    = 1'b0;
      m_armed  = 1'b1;
    end else if (c) begin
      m = '0;
    end else begin
      m.strobe = '0;
      m.err    = 1'b0;
      if (w) begin
        if (s < 3'd6) begin
          m.d[s]      = din;
          m.strobe[s] = 1'b1;
          m.mask[s]   = 1'b1;
        end else begin
          m.err = 1'b1;
        end
      end
    end
    q_exp.push_back(m);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b0; Write = 1'b0; Clear = 1'b0; Selector = '0; Data_in = '0;
    m = '0; m_armed = 1'b0;
    #2;
    chk("reset_data0", Data_0, '0);
    chk("reset_mask",  {26'd0, Written_mask}, '0);

    step(1'b0, 1'b0, 1'b0, 3'd0, '0);
    step(1'b1, 1'b0, 1'b0, 3'd0, '0);            // release, idle edge

    // Single write to destination 2
    step(1'b1, 1'b1, 1'b0, 3'd2, 32'hDEADBEEF);
    after_edge();
    chk("w2_data2",  Data_2, 32'hDEADBEEF);
    chk("w2_strobe", {26'd0, Load_strobe},  32'h04);
    chk("w2_mask",   {26'd0, Written_mask}, 32'h04);
    chk("w2_data0",  Data_0, '0);

    // Walk all six destinations, data = k+1
    for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 1'b0, 3'(k), 32'(k + 1));
    after_edge();
    chk("walk_strobe", {26'd0, Load_strobe},  32'h20);
    chk("walk_mask",   {26'd0, Written_mask}, 32'h3F);
    chk("walk_data3",  Data_3, 32'd4);

    // Write=0 holds everything regardless of selector/data
    step(1'b1, 1'b0, 1'b0, 3'd1, 32'h12345678);
    after_edge();
    chk("hold_data1",  Data_1, 32'd2);
    chk("hold_strobe", {26'd0, Load_strobe}, '0);

    // Illegal selectors
    step(1'b1, 1'b1, 1'b0, 3'd7, 32'hFFFFFFFF);
    after_edge();
    chk("sel7_err",    {31'd0, Sel_error}, 32'd1);
    chk("sel7_strobe", {26'd0, Load_strobe}, '0);
    chk("sel7_data5",  Data_5, 32'd6);
    step(1'b1, 1'b1, 1'b0, 3'd6, 32'hAAAAAAAA);
    step(1'b1, 1'b0, 1'b0, 3'd0, '0);
    after_edge();
    chk("err_pulse_end", {31'd0, Sel_error}, '0);

    // Clear beats a simultaneous write
    step(1'b1, 1'b1, 1'b0, 3'd1, 32'h5);
    step(1'b1, 1'b1, 1'b1, 3'd1, 32'h99);
    after_edge();
    chk("clr_data1",  Data_1, '0);
    chk("clr_mask",   {26'd0, Written_mask}, '0);
    chk("clr_strobe", {26'd0, Load_strobe}, '0);

    // Back-to-back writes to destination 4
    step(1'b1, 1'b1, 1'b0, 3'd4, 32'hA);
    after_edge();
    chk("b2b_strobe1", {26'd0, Load_strobe}, 32'h10);
    step(1'b1, 1'b1, 1'b0, 3'd4, 32'hB);
    after_edge();
    chk("b2b_strobe2", {26'd0, Load_strobe}, 32'h10);
    chk("b2b_data4",   Data_4, 32'hB);

    // Asynchronous reset between edges while a strobe is pending
    step(1'b1, 1'b1, 1'b0, 3'd3, 32'h33);
    after_edge();
    #1 reset = 1'b0;
    #1;
    chk("arst_data3",  Data_3, '0);
    chk("arst_data4",  Data_4, '0);
    chk("arst_strobe", {26'd0, Load_strobe},  '0);
    chk("arst_mask",   {26'd0, Written_mask}, '0);
    m = '0; m_armed = 1'b0;
    step(1'b0, 1'b1, 1'b0, 3'd5, 32'h44);        // ignored while in reset
    step(1'b1, 1'b1, 1'b0, 3'd5, 32'h55);        // ignored on release edge
    after_edge();
    chk("release_data5", Data_5, '0);
    step(1'b1, 1'b1, 1'b0, 3'd5, 32'h77);
    after_edge();
    chk("first_write_data5", Data_5, 32'h77);
    step(1'b1, 1'b0, 1'b0, 3'd0, '0);
    step(1'b1, 1'b0, 1'b0, 3'd0, '0);

    after_edge();
    after_edge();
    chk("queue_drained", 32'(q_exp.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got no completion, want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/demux_1x6_reg.md
DEMUX_1X6_REG -- requirements
Module: demux_1x6_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data width of Data_in and of every Data_k output.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port Data_in, input, WIDTH bits: the write data.
REQ-005 The block SHALL have port Selector, input, 3 bits: the destination index; 0-5 are valid, 6-7 are illegal.
REQ-006 The block SHALL have port Write, input, 1 bit: write request, sampled on each rising edge.
REQ-007 The block SHALL have port Clear, input, 1 bit: synchronous clear of all outputs and the mask.
REQ-008 The block SHALL have ports Data_0 .. Data_5, output, WIDTH bits each: registered destination values.
REQ-009 The block SHALL have port Load_strobe, output, 6 bits: bit k pulses for one cycle after Data_k is loaded.
REQ-010 The block SHALL have port Written_mask, output, 6 bits: bit k is sticky and set once Data_k has been written since the last reset or Clear.
REQ-011 The block SHALL have port Sel_error, output, 1 bit: one-cycle pulse after a Write with an illegal Selector.

Function
REQ-012 The block SHALL load Data_in into Data_k (k = Selector) when, on a rising edge, Write=1, Clear=0 and Selector<6; Data_k shows the value one edge after sampling.
REQ-013 The block SHALL hold every Data_j with j != Selector unchanged on a write.
REQ-014 The block SHALL hold all Data_k, Written_mask and internal state on any edge with Write=0 and Clear=0.
REQ-015 The block SHALL drive Load_strobe[k]=1 during exactly the cycle after a legal write to k, and 0 otherwise; at most one bit is set at a time.
REQ-016 The block SHALL set Written_mask[k] on a legal write to k and keep it set until reset or Clear.
REQ-017 The block SHALL leave Data_0..Data_5, Written_mask and Load_strobe unchanged (Load_strobe=0) for Write=1 with Selector=6 or 7, and SHALL drive Sel_error=1 for the following cycle only.
REQ-018 The block SHALL give Clear=1 priority over Write: on that edge all Data_k become 0, Written_mask becomes 0, and Load_strobe and Sel_error are 0 in the next cycle.
REQ-019 The block SHALL support back-to-back writes, one per cycle, including repeated writes to the same k; the last write wins and Load_strobe[k] stays high for each consecutive cycle that follows a write to k.
REQ-020 The block SHALL pass data with no arithmetic or width change; the full WIDTH bits are stored.

Reset
REQ-021 The block SHALL, on reset=0, immediately and asynchronously force Data_0..Data_5=0, Load_strobe=0, Written_mask=0 and Sel_error=0, independent of clk.
REQ-022 The block SHALL ignore Write and Clear while reset=0; a write sampled on the edge where reset rises is ignored, and the first write is accepted on the next edge.
REQ-023 The block SHALL allow reset to be asserted mid-sequence, discarding any pending strobe or error pulse.

Structure
REQ-024 A shared header SHALL hold the constants for the destination count (6) and the illegal selector values (6, 7); WIDTH stays a module parameter.
REQ-025 The block SHALL instantiate one sub-module, reg_en_clr (WIDTH-bit register with enable, synchronous clear and asynchronous active-low reset), six times, once per Data_k.
REQ-026 Decode, strobe, mask and error logic SHALL live in demux_1x6_reg itself; the block has no combinational path from inputs to outputs.

Verification
REQ-027 Scenario: reset, then Write=1, Selector=2, Data_in=0xDEADBEEF -> next cycle Data_2=0xDEADBEEF, Load_strobe=6'b000100, Written_mask=6'b000100, and all other Data_k=0.
REQ-028 Scenario: writes to Selector 0..5 on consecutive cycles with Data_in=k+1 -> Data_k=k+1, Load_strobe walks one-hot one cycle behind, and final Written_mask=6'b111111.
REQ-029 Scenario: Write=1, Selector=7, Data_in=0xFFFFFFFF -> Sel_error=1 for one cycle, Load_strobe=0, and all Data_k and Written_mask unchanged.
REQ-030 Scenario: Clear=1 and Write=1 with Selector=1 on the same edge, after Data_1=0x5 -> Data_1=0, Written_mask=0, Load_strobe=0.
REQ-031 Scenario: reset pulled low between clock edges after writes -> all outputs read 0 before the next edge; a write sampled on the reset-release edge is ignored.
REQ-032 Scenario: two writes to Selector 4 (0xA then 0xB) on consecutive cycles -> Data_4=0xB, and Load_strobe[4] is high for two consecutive cycles.
